// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, instruction formats and the decoded bundle
// carried from decode to execute.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    TYPE_R       = 3'd0,
    TYPE_I       = 3'd1,
    TYPE_S       = 3'd2,
    TYPE_B       = 3'd3,
    TYPE_U       = 3'd4,
    TYPE_J       = 3'd5,
    TYPE_ILLEGAL = 3'd6
  } instr_type_e;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    instr_type_e     instr_type;
  } decoded_instr_t;

  function automatic instr_type_e classify(input logic [6:0] opcode);
    case (opcode)
      OP_R:                                  return TYPE_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:   return TYPE_I;
      OP_STORE:                              return TYPE_S;
      OP_BRANCH:                             return TYPE_B;
      OP_LUI, OP_AUIPC:                      return TYPE_U;
      OP_JAL:                                return TYPE_J;
      default:                               return TYPE_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/decode_ifs.sv
// Stage-to-stage interfaces around decode: fetch->decode, decode->execute and
// the register file read ports.
interface fetch_decode_if;
  import riscv_pkg::*;
  logic [XLEN-1:0] instruction;
  logic [XLEN-1:0] pc;
  logic            valid;
  logic            ready;
  modport fetch  (output instruction, output pc, output valid, input ready);
  modport decode (input instruction, input pc, input valid, output ready);
endinterface

interface decode_execute_if;
  import riscv_pkg::*;
  // valid/ready: a bundle transfers on a cycle where both are high; while valid
  // is high and ready is low the producer holds every field stable.
  logic            valid;
  logic            ready;
  decoded_instr_t  decoded_instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            illegal;
  modport decode  (output valid, input ready, output decoded_instr, output pc,
                   output rs1_data, output rs2_data, output illegal);
  modport execute (input valid, output ready, input decoded_instr, input pc,
                   input rs1_data, input rs2_data, input illegal);
endinterface

interface register_file_if;
  import riscv_pkg::*;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] data_out_rs1;
  logic [XLEN-1:0] data_out_rs2;
  modport decode  (output rs1_addr, output rs2_addr, input data_out_rs1, input data_out_rs2);
  modport regfile (input rs1_addr, input rs2_addr, output data_out_rs1, output data_out_rs2);
endinterface

// File: rtl/decode_imm_gen.sv
// Combinational immediate generator: picks and sign-extends the immediate field
// for the given instruction format; R and ILLEGAL yield zero.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] i_instr,
  input  instr_type_e i_type,
  output logic [31:0] o_imm
);

  logic w_unused_opcode;
  assign w_unused_opcode = ^i_instr[6:0];

  always_comb begin
    o_imm = '0;
    case (i_type)
      TYPE_I:  o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      TYPE_S:  o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      TYPE_B:  o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                        i_instr[11:8], 1'b0};
      TYPE_U:  o_imm = {i_instr[31:12], 12'b0};
      TYPE_J:  o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                        i_instr[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: splits the fetched word into fields, builds the immediate and
// registers operands for execute. DECODE_ILLEGAL_CHECK_EN enables the illegal flag.
module decode #(
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               rst,
  fetch_decode_if.decode    fd_if,
  register_file_if.decode   rf_if,
  decode_execute_if.decode  de_if
);
  import riscv_pkg::*;

  logic            w_load;
  logic [31:0]     w_instr;
  instr_type_e     w_raw_type;
  instr_type_e     w_type;
  logic            w_illegal;
  logic [31:0]     w_imm;
  decoded_instr_t  w_decoded;

  logic            r_valid;
  decoded_instr_t  r_decoded;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic            r_illegal;

  assign w_instr     = fd_if.instruction;
  assign fd_if.ready = !rst && (de_if.ready || !r_valid);
  assign w_load      = fd_if.valid && fd_if.ready;

  assign rf_if.rs1_addr = w_instr[19:15];
  assign rf_if.rs2_addr = w_instr[24:20];

  assign w_raw_type = classify(w_instr[6:0]);

`ifdef DECODE_ILLEGAL_CHECK_EN
  assign w_type    = w_raw_type;
  assign w_illegal = (w_raw_type == TYPE_ILLEGAL);
`else
  // Unknown opcodes masquerade as R-type so execute sees a harmless zero immediate.
  assign w_type    = (w_raw_type == TYPE_ILLEGAL) ? TYPE_R : w_raw_type;
  assign w_illegal = 1'b0;
`endif

  imm_gen u_imm_gen (
    .i_instr (w_instr),
    .i_type  (w_type),
    .o_imm   (w_imm)
  );

  always_comb begin
    w_decoded            = '0;
    w_decoded.opcode     = w_instr[6:0];
    w_decoded.rd         = w_instr[11:7];
    w_decoded.funct3     = w_instr[14:12];
    w_decoded.rs1        = w_instr[19:15];
    w_decoded.rs2        = w_instr[24:20];
    w_decoded.funct7     = w_instr[31:25];
    w_decoded.imm        = w_imm;
    w_decoded.instr_type = w_type;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_decoded  <= '0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_illegal  <= 1'b0;
    end else if (w_load) begin
      r_valid    <= 1'b1;
      r_decoded  <= w_decoded;
      r_pc       <= fd_if.pc;
      r_rs1_data <= rf_if.data_out_rs1;
      r_rs2_data <= rf_if.data_out_rs2;
      r_illegal  <= w_illegal;
    end else if (de_if.ready) begin
      r_valid <= 1'b0;
    end
  end

  assign de_if.valid         = r_valid;
  assign de_if.decoded_instr = r_decoded;
  assign de_if.pc            = r_pc;
  assign de_if.rs1_data      = r_rs1_data;
  assign de_if.rs2_data      = r_rs2_data;
  assign de_if.illegal       = r_illegal;

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage: hand-computed field/immediate values,
// stall hold, mid-stream reset and illegal-opcode handling.
module tb_decode;
  import riscv_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] rf_regs[32];
  int          total;
  int          bad;

  fetch_decode_if   fd();
  decode_execute_if de();
  register_file_if  rf();

  decode #(.XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .fd_if (fd),
    .rf_if (rf),
    .de_if (de)
  );

  assign rf.data_out_rs1 = rf_regs[rf.rs1_addr];
  assign rf.data_out_rs2 = rf_regs[rf.rs2_addr];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    fd.instruction = instr;
    fd.pc          = pc;
    fd.valid       = 1'b1;
  endtask

  task automatic check_bundle(input string tag, input logic [6:0] opcode, input logic [4:0] rd,
                              input logic [31:0] imm, input instr_type_e typ,
                              input logic [31:0] pc);
    check({tag, ".valid"},  32'(de.valid), 32'd1);
    check({tag, ".opcode"}, 32'(de.decoded_instr.opcode), 32'(opcode));
    check({tag, ".rd"},     32'(de.decoded_instr.rd), 32'(rd));
    check({tag, ".imm"},    de.decoded_instr.imm, imm);
    check({tag, ".type"},   32'(de.decoded_instr.instr_type), 32'(typ));
    check({tag, ".pc"},     de.pc, pc);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 32; i++) rf_regs[i] = 32'hA000_0000 + 32'(i);
    rf_regs[0] = 32'h0;
    rf_regs[1] = 32'h10;
    rf_regs[2] = 32'h20;
    rst = 1'b1;
    de.ready = 1'b1;
    fd.valid = 1'b0;
    fd.instruction = 32'h0;
    fd.pc = 32'h0;
    step();
    step();

    check("rst.valid",   32'(de.valid), 32'd0);
    check("rst.opcode",  32'(de.decoded_instr.opcode), 32'd0);
    check("rst.imm",     de.decoded_instr.imm, 32'd0);
    check("rst.pc",      de.pc, 32'd0);
    check("rst.rs1",     de.rs1_data, 32'd0);
    check("rst.illegal", 32'(de.illegal), 32'd0);
    check("rst.fd_ready", 32'(fd.ready), 32'd0);
    rst = 1'b0;
    #1;
    check("fd_ready_idle", 32'(fd.ready), 32'd1);

    // ADDI x1,x0,5
    present(32'h00500093, 32'h100);
    step();
    check_bundle("addi", 7'h13, 5'd1, 32'd5, TYPE_I, 32'h100);
    check("addi.rs1", 32'(de.decoded_instr.rs1), 32'd0);

    // ADD x3,x1,x2 back-to-back
    present(32'h002081B3, 32'h104);
    #1;
    check("add.rs1_addr", 32'(rf.rs1_addr), 32'd1);
    check("add.rs2_addr", 32'(rf.rs2_addr), 32'd2);
    step();
    check_bundle("add", 7'h33, 5'd3, 32'd0, TYPE_R, 32'h104);
    check("add.rs1_data", de.rs1_data, 32'h10);
    check("add.rs2_data", de.rs2_data, 32'h20);
    check("add.funct3",   32'(de.decoded_instr.funct3), 32'd0);
    check("add.funct7",   32'(de.decoded_instr.funct7), 32'd0);

    // SW x2,8(x1) then BEQ -4
    present(32'h0020A423, 32'h108);
    step();
    check_bundle("sw", 7'h23, 5'd8, 32'd8, TYPE_S, 32'h108);
    check("sw.funct3", 32'(de.decoded_instr.funct3), 32'd2);
    present(32'hFE208EE3, 32'h10C);
    step();
    check_bundle("beq", 7'h63, 5'd29, 32'hFFFFFFFC, TYPE_B, 32'h10C);

    // LUI x5 then JAL x1,8
    present(32'h123452B7, 32'h110);
    step();
    check_bundle("lui", 7'h37, 5'd5, 32'h12345000, TYPE_U, 32'h110);
    present(32'h008000EF, 32'h114);
    step();
    check_bundle("jal", 7'h6F, 5'd1, 32'd8, TYPE_J, 32'h114);

    // stall: ADDI x2,x0,10 held while ADDI x3,x0,3 waits
    present(32'h00A00113, 32'h118);
    step();
    de.ready = 1'b0;
    present(32'h00300193, 32'h11C);
    #1;
    check("stall.fd_ready", 32'(fd.ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check_bundle("stall", 7'h13, 5'd2, 32'd10, TYPE_I, 32'h118);
      check("stall.fd_ready_hold", 32'(fd.ready), 32'd0);
    end
    de.ready = 1'b1;
    #1;
    check("unstall.fd_ready", 32'(fd.ready), 32'd1);
    step();
    check_bundle("unstall", 7'h13, 5'd3, 32'd3, TYPE_I, 32'h11C);
    fd.valid = 1'b0;
    step();
    check("drain.valid", 32'(de.valid), 32'd0);

    // reset with a pending bundle and a simultaneous load request
    present(32'h008000EF, 32'h120);
    step();
    de.ready = 1'b0;
    rst = 1'b1;
    present(32'h123452B7, 32'h124);
    step();
    check("midrst.valid",    32'(de.valid), 32'd0);
    check("midrst.rd",       32'(de.decoded_instr.rd), 32'd0);
    check("midrst.imm",      de.decoded_instr.imm, 32'd0);
    check("midrst.pc",       de.pc, 32'd0);
    check("midrst.fd_ready", 32'(fd.ready), 32'd0);
    rst = 1'b0;
    de.ready = 1'b1;
    fd.valid = 1'b0;
    step();

    // opcode 0x7F with bit31 set: immediate must stay zero either way
    present(32'h800000FF, 32'h128);
    step();
`ifdef DECODE_ILLEGAL_CHECK_EN
    check_bundle("illegal", 7'h7F, 5'd1, 32'd0, TYPE_ILLEGAL, 32'h128);
    check("illegal.flag", 32'(de.illegal), 32'd1);
`else
    check_bundle("illegal", 7'h7F, 5'd1, 32'd0, TYPE_R, 32'h128);
    check("illegal.flag", 32'(de.illegal), 32'd0);
`endif
    fd.valid = 1'b0;
    step();
    check("final.valid", 32'(de.valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode.md
# decode

Second stage of the five-stage RV32I pipeline, between fetch and execute. Accepts one instruction word and PC per cycle from fetch and splits it into fields. It generates the sign-extended immediate and captures both source operands from the register file's combinational read ports. Presents the registered result to execute under a valid/ready handshake.

## Interface
Parameters:
- XLEN, 32, data/address width (only 32 supported)

Ports (signal groups carried in the interfaces fd_if, de_if, rf_if):
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- fd_if.instruction  in  32  instruction word from fetch
- fd_if.pc  in  32  PC of that instruction
- fd_if.valid  in  1  instruction/PC valid
- fd_if.ready  out  1  decode can accept this cycle
- rf_if.rs1_addr / rf_if.rs2_addr  out  5 each  register read addresses, instruction[19:15] / [24:20]
- rf_if.data_out_rs1 / rf_if.data_out_rs2  in  32 each  combinational read data
- de_if.valid  out  1  decoded bundle valid
- de_if.ready  in  1  execute accepts bundle
- de_if.decoded_instr  out  struct  decoded_instr_t: opcode[6:0], rd[4:0], rs1[4:0], rs2[4:0], funct3[2:0], funct7[6:0], imm[31:0], instr_type
- de_if.pc  out  32  PC of decoded instruction
- de_if.rs1_data / de_if.rs2_data  out  32 each  operand values
- de_if.illegal  out  1  unrecognised opcode flag

## Operation
- Output register loads when fd_if.valid && fd_if.ready, with fields from the instruction, imm from imm_gen, and rs data from rf_if.
- fd_if.ready = !rst && (de_if.ready || !de_if.valid), combinational.
- rd is decoded verbatim for every format. S and B formats still report bits [11:7] and do not write a register. Execute uses instr_type to gate writeback.
- instr_type by opcode:
  - R 0110011
  - I 0010011/0000011/1100111/1110011
  - S 0100011
  - B 1100011
  - U 0110111/0010111
  - J 1101111
  - any other opcode is ILLEGAL
- Immediates, all sign-extended from instruction[31]:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}, no extension needed
  - J: {[31],[19:12],[20],[30:21],0}
  - R: 0
- Handshake:
  - de_if.valid is set on a load.
  - de_if.valid clears when de_if.ready && !(fd_if.valid && fd_if.ready).
  - When de_if.valid && !de_if.ready (stall), all de_if outputs hold stable.
- Reset:
  - de_if.valid = 0.
  - decoded_instr, pc, rs data and illegal are all zero.
  - Reset wins over a simultaneous load.
  - A bundle pending at reset is discarded.

## Timing
- Latency is 1 cycle: inputs present before edge N appear on de_if after edge N.
- Back-to-back throughput is one instruction per cycle while de_if.ready = 1.
- Register read is combinational in the cycle the instruction is presented. No write-bypass in this block.
- fd_if.ready has a combinational path from de_if.ready.

## Configuration
- DECODE_ILLEGAL_CHECK_EN defined:
  - de_if.illegal = 1 for ILLEGAL instr_type.
  - The bundle is still passed with imm = 0.
- DECODE_ILLEGAL_CHECK_EN undefined:
  - de_if.illegal tied 0.
  - Unknown opcodes decode as R-type with imm = 0.

## Structure
- riscv_pkg holds:
  - opcode constants
  - instr_type_e enum
  - decoded_instr_t struct
  - XLEN
- fetch_decode_if, decode_execute_if and register_file_if hold modports for decode and the neighbouring stages.
- One sub-module: imm_gen, a combinational instruction-to-immediate function taking the instruction and instr_type.

## Test plan
- 0x00500093 (ADDI x1,x0,5), fd_if.valid = 1 -> next cycle de_if.valid = 1, opcode 0x13, rd 1, rs1 0, imm 5, type I.
- 0x002081B3 (ADD x3,x1,x2), rs1 = 0x10, rs2 = 0x20 -> opcode 0x33, rd 3, rs1_data 0x10, rs2_data 0x20, imm 0.
- 0x0020A423 (SW x2,8(x1)) -> opcode 0x23, imm 8, type S. Then 0xFE208EE3 (BEQ -4) -> imm 0xFFFFFFFC, type B.
- 0x123452B7 (LUI x5) -> rd 5, imm 0x12345000. Then 0x008000EF (JAL x1,8) -> imm 8, rd 1.
- de_if.ready = 0 while valid for 3 cycles -> outputs stable, fd_if.ready = 0. Ready returns -> next instruction loads.
- Assert rst mid-stream -> de_if.valid = 0 next cycle. Opcode 0x7F -> illegal = 1 only when DECODE_ILLEGAL_CHECK_EN is defined.
